// File: rtl/gvp_stream_packer_pkg.sv
// Shared types and constants for the GVP stream packer: trigger codes,
// packet lengths, word-0 layout and the latched snapshot record.
package gvp_stream_pkg;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_DATA = 2'd1,
      ST_HDR  = 2'd2,
      ST_END  = 2'd3
   } store_e;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam int HDR_WORDS   = 8;
   localparam int END_WORDS   = 3;
   localparam int W0_TYPE_LSB = 30;
   localparam int W0_NW_LSB   = 24;
   localparam int W0_IDX_W    = 24;

   typedef struct packed {
      logic [1:0]  kind;
      logic [23:0] index;
      logic [47:0] gtime;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] z;
      logic [31:0] u;
      logic [31:0] options;
   } snap_t;

   function automatic logic [31:0] mk_w0(input logic [1:0] kind, input logic [5:0] nw,
                                         input logic [23:0] idx);
      logic [31:0] w;
      w = '0;
      w[W0_TYPE_LSB +: 2]  = kind;
      w[W0_NW_LSB +: 6]    = nw;
      w[0 +: W0_IDX_W]     = idx;
      return w;
   endfunction

   function automatic logic [5:0] popcount16(input logic [15:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + 6'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/gvp_stream_packer_if.sv
// 32-bit AXI-Stream link from the packer to the DMA/FIFO.
interface gvp_stream_packer_if;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gvp_stream_packer_srcs.sv
// Source-mask latch: registered popcount plus a finder that maps a packet
// word pointer (1..P) to the index of the matching selected source.
module gvp_srcs_select
   import gvp_stream_pkg::*;
#(
   parameter int NUM_SRCS = 16,
   parameter int IDX_W    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_i,
   input  logic [NUM_SRCS-1:0] mask_i,
   input  logic [5:0]          word_ptr_i,
   output logic [5:0]          pcnt_o,
   output logic [IDX_W-1:0]    src_idx_o
);
   logic [NUM_SRCS-1:0] mask_q;
   logic [5:0]          pcnt_q;
   logic [5:0]          seen;
   logic [5:0]          target;

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q <= '0;
         pcnt_q <= '0;
      end else if (load_i) begin
         mask_q <= mask_i;
         pcnt_q <= popcount16(16'(mask_i));
      end
   end

   assign pcnt_o = pcnt_q;
   assign target = word_ptr_i - 6'd1;

   // Word 1 carries the lowest selected source, word 2 the next, and so on.
   always_comb begin
      src_idx_o = '0;
      seen      = '0;
      for (int k = 0; k < NUM_SRCS; k++) begin
         if (mask_q[k]) begin
            if (seen == target) src_idx_o = IDX_W'(k);
            seen = seen + 6'd1;
         end
      end
   end

endmodule

// File: rtl/gvp_stream_packer.sv
// Snapshots GVP state on each store trigger and emits it as one framed
// AXI-Stream packet; back-pressure is reflected to the GVP via stall.
module gvp_stream_packer
   import gvp_stream_pkg::*;
#(
   parameter int NUM_SRCS = 16
) (
   input  logic                   a_clk,
   input  logic                   reset,
   input  logic [1:0]             store_data,
   input  logic [31:0]            index,
   input  logic [47:0]            gvp_time,
   input  logic [31:0]            pos_x,
   input  logic [31:0]            pos_y,
   input  logic [31:0]            pos_z,
   input  logic [31:0]            pos_u,
   input  logic [31:0]            options,
   input  logic [NUM_SRCS*32-1:0] src_data,
   gvp_stream_packer_if.master    M_AXIS,
   output logic                   stall,
   output logic                   busy,
   output logic [31:0]            packet_count,
   output logic [15:0]            overrun_count
);
   localparam int IDX_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

   state_e                     state_q;
   logic [1:0]                 store_q;
   logic [31:0]                index_q;
   logic [5:0]                 ptr_q;
   snap_t                      snap_q, snap_d;
   logic [NUM_SRCS-1:0][31:0]  src_q;
   logic [31:0]                pkt_cnt_q;
   logic [15:0]                ovr_cnt_q, ovr_cnt_d;

   logic             trig, hs, last, accept, snap;
   logic [5:0]       pcnt, nwords;
   logic [IDX_W-1:0] src_idx;
   logic [31:0]      w0, word;

   assign trig   = (store_data != 2'd0) && ((store_data != store_q) || (index != index_q));
   assign hs     = (state_q == SEND) && M_AXIS.tready;
   assign last   = (ptr_q == nwords - 6'd1);
   assign accept = (state_q == IDLE) || (hs && last);
   assign snap   = trig && accept;

   assign snap_d = '{kind: store_data, index: index[23:0], gtime: gvp_time,
                     x: pos_x, y: pos_y, z: pos_z, u: pos_u, options: options};
   assign ovr_cnt_d = (ovr_cnt_q == 16'hFFFF) ? ovr_cnt_q : ovr_cnt_q + 16'd1;

   gvp_srcs_select #(.NUM_SRCS(NUM_SRCS), .IDX_W(IDX_W)) u_srcs (
      .clk        (a_clk),
      .reset      (reset),
      .load_i     (snap),
      .mask_i     (options[16 +: NUM_SRCS]),
      .word_ptr_i (ptr_q),
      .pcnt_o     (pcnt),
      .src_idx_o  (src_idx)
   );

   always_comb begin
      nwords = 6'd0;
      case (snap_q.kind)
         ST_HDR:  nwords = 6'(HDR_WORDS);
         ST_END:  nwords = 6'(END_WORDS);
         ST_DATA: nwords = 6'd1 + pcnt;
         default: nwords = 6'd0;
      endcase
   end

   assign w0 = mk_w0(snap_q.kind, nwords, snap_q.index);

   // Header and end packets share the same word layout for words 0..2.
   always_comb begin
      word = '0;
      if (snap_q.kind == ST_DATA) begin
         word = (ptr_q == 6'd0) ? w0 : src_q[src_idx];
      end else begin
         case (ptr_q)
            6'd0:    word = w0;
            6'd1:    word = snap_q.gtime[31:0];
            6'd2:    word = {16'h0, snap_q.gtime[47:32]};
            6'd3:    word = snap_q.x;
            6'd4:    word = snap_q.y;
            6'd5:    word = snap_q.z;
            6'd6:    word = snap_q.u;
            6'd7:    word = snap_q.options;
            default: word = '0;
         endcase
      end
   end

   always_ff @(posedge a_clk) begin
      if (reset) begin
         state_q   <= IDLE;
         store_q   <= '0;
         index_q   <= '0;
         ptr_q     <= '0;
         snap_q    <= '0;
         src_q     <= '0;
         pkt_cnt_q <= '0;
         ovr_cnt_q <= '0;
      end else begin
         store_q <= store_data;
         index_q <= index;
         if (snap) begin
            state_q <= SEND;
            ptr_q   <= '0;
            snap_q  <= snap_d;
            src_q   <= src_data;
         end else if (hs) begin
            if (last) begin
               state_q <= IDLE;
               ptr_q   <= '0;
            end else begin
               ptr_q <= ptr_q + 6'd1;
            end
         end
         if (hs && last)      pkt_cnt_q <= pkt_cnt_q + 32'd1;
         if (trig && !accept) ovr_cnt_q <= ovr_cnt_d;
      end
   end

   assign M_AXIS.tvalid = (state_q == SEND);
   assign M_AXIS.tlast  = (state_q == SEND) && last;
   assign M_AXIS.tdata  = (state_q == SEND) ? word : 32'h0;
   assign busy          = (state_q == SEND);
   assign stall         = busy || !M_AXIS.tready;
   assign packet_count  = pkt_cnt_q;
   assign overrun_count = ovr_cnt_q;

endmodule

// File: tb/tb_gvp_stream_packer.sv
// Directed scoreboard bench for gvp_stream_packer.
module tb_gvp_stream_packer;
   localparam int NUM_SRCS = 16;

   logic                   a_clk = 1'b0;
   logic                   reset = 1'b1;
   logic [1:0]             store_data = '0;
   logic [31:0]            index = '0;
   logic [47:0]            gvp_time = '0;
   logic [31:0]            pos_x = '0, pos_y = '0, pos_z = '0, pos_u = '0;
   logic [31:0]            options = '0;
   logic [NUM_SRCS*32-1:0] src_data = '0;
   logic                   stall, busy;
   logic [31:0]            packet_count;
   logic [15:0]            overrun_count;

   gvp_stream_packer_if axis();

   gvp_stream_packer #(.NUM_SRCS(NUM_SRCS)) dut (
      .a_clk         (a_clk),
      .reset         (reset),
      .store_data    (store_data),
      .index         (index),
      .gvp_time      (gvp_time),
      .pos_x         (pos_x),
      .pos_y         (pos_y),
      .pos_z         (pos_z),
      .pos_u         (pos_u),
      .options       (options),
      .src_data      (src_data),
      .M_AXIS        (axis),
      .stall         (stall),
      .busy          (busy),
      .packet_count  (packet_count),
      .overrun_count (overrun_count)
   );

   always #5 a_clk = ~a_clk;

   int          checks = 0;
   int          failures = 0;
   bit          mon_en = 1'b0;
   logic [32:0] exp_q[$];
   logic [32:0] mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input bit last);
      exp_q.push_back({last, d});
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge a_clk);
         #1;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic push_hdr(input logic [31:0] w0);
      push(w0, 1'b0);
      push(32'h5678_9ABC, 1'b0);
      push(32'h0000_1234, 1'b0);
      push(32'h0000_0010, 1'b0);
      push(32'h0000_0020, 1'b0);
      push(32'h0000_0030, 1'b0);
      push(32'h0000_0040, 1'b0);
      push(32'h0003_0000, 1'b1);
   endtask

   // Monitor: every handshake must match the head of the expected queue.
   always @(negedge a_clk) begin
      if (mon_en && axis.tvalid && axis.tready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h expected=none", {axis.tlast, axis.tdata});
         end else begin
            mon_e = exp_q.pop_front();
            chk("stream_word", 64'({axis.tlast, axis.tdata}), 64'(mon_e));
         end
      end
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog actual=timeout expected=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      axis.tready = 1'b0;
      gvp_time = 48'h1234_5678_9ABC;
      pos_x = 32'h10; pos_y = 32'h20; pos_z = 32'h30; pos_u = 32'h40;
      tick(3);
      chk("rst_tvalid", axis.tvalid, 0);
      chk("rst_tlast", axis.tlast, 0);
      chk("rst_tdata", axis.tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall_notready", stall, 1);
      chk("rst_pkt_cnt", packet_count, 0);
      chk("rst_ovr_cnt", overrun_count, 0);
      axis.tready = 1'b1;
      #1;
      chk("rst_stall_ready", stall, 0);
      reset = 1'b0;
      mon_en = 1'b1;

      // Header packet
      index = 32'd5; options = 32'h0003_0000; store_data = 2'd2;
      push_hdr(32'h8800_0005);
      tick();
      chk("hdr_first_valid", axis.tvalid, 1);
      chk("hdr_busy", busy, 1);
      drain("hdr_drain");
      chk("hdr_pkt_cnt", packet_count, 1);
      store_data = 2'd0;

      // Data packet, mask changes after snapshot
      tick();
      src_data[0*32 +: 32] = 32'hA;
      src_data[1*32 +: 32] = 32'hB;
      src_data[2*32 +: 32] = 32'hC;
      options = 32'h0005_0000; index = 32'd6; store_data = 2'd1;
      push(32'h4300_0006, 1'b0);
      push(32'h0000_000A, 1'b0);
      push(32'h0000_000C, 1'b1);
      tick();
      options = 32'h0007_0000;
      drain("data_drain");
      chk("data_pkt_cnt", packet_count, 2);
      store_data = 2'd0;

      // Back-to-back: index steps on the last-word handshake
      tick();
      options = 32'h0001_0000; index = 32'd9; store_data = 2'd1;
      push(32'h4200_0009, 1'b0);
      push(32'h0000_000A, 1'b1);
      push(32'h4200_0008, 1'b0);
      push(32'h0000_000A, 1'b1);
      tick();
      tick();
      chk("b2b_first_last", axis.tlast, 1);
      index = 32'd8;
      tick();
      chk("b2b_second_valid", axis.tvalid, 1);
      chk("b2b_second_w0", axis.tdata, 32'h4200_0008);
      drain("b2b_drain");
      chk("b2b_ovr_cnt", overrun_count, 0);
      chk("b2b_pkt_cnt", packet_count, 4);
      store_data = 2'd0;

      // Backpressure and overrun
      tick();
      axis.tready = 1'b0;
      index = 32'h20; options = 32'h0003_0000; store_data = 2'd2;
      push_hdr(32'h8800_0020);
      tick();
      chk("bp_stall", stall, 1);
      chk("bp_w0", axis.tdata, 32'h8800_0020);
      tick(3);
      chk("bp_hold_data", axis.tdata, 32'h8800_0020);
      chk("bp_hold_valid", axis.tvalid, 1);
      store_data = 2'd3;
      tick();
      chk("bp_ovr_cnt", overrun_count, 1);
      tick(2);
      axis.tready = 1'b1;
      drain("bp_drain");
      chk("bp_pkt_cnt", packet_count, 5);
      store_data = 2'd0;

      // End code held: exactly one packet
      tick();
      index = 32'h33; gvp_time = 48'hABCD_0000_0001; store_data = 2'd3;
      push(32'hC300_0033, 1'b0);
      push(32'h0000_0001, 1'b0);
      push(32'h0000_ABCD, 1'b1);
      tick(100);
      chk("end_drained", 64'(exp_q.size()), 0);
      chk("end_pkt_cnt", packet_count, 6);
      store_data = 2'd0;

      // Reset mid-packet after three words
      tick();
      index = 32'd7; gvp_time = 48'h1234_5678_9ABC; store_data = 2'd2;
      push(32'h8800_0007, 1'b0);
      push(32'h5678_9ABC, 1'b0);
      push(32'h0000_1234, 1'b0);
      tick(3);
      reset = 1'b1;
      tick();
      chk("abort_tvalid", axis.tvalid, 0);
      chk("abort_tlast", axis.tlast, 0);
      chk("abort_tdata", axis.tdata, 0);
      chk("abort_busy", busy, 0);
      chk("abort_pkt_cnt", packet_count, 0);
      chk("abort_ovr_cnt", overrun_count, 0);
      chk("abort_words_seen", 64'(exp_q.size()), 0);
      tick();
      push_hdr(32'h8800_0007);
      reset = 1'b0;
      tick();
      chk("post_rst_valid", axis.tvalid, 1);
      drain("post_rst_drain");
      chk("post_rst_pkt_cnt", packet_count, 1);
      store_data = 2'd0;

      tick(5);
      chk("final_queue_empty", 64'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
